// File: rtl/rob_dual_commit.sv
// Reorder buffer with two writeback ports, two query ports and in-order dual commit.
// Commit and query are combinational from state; alloc backpressured by full; redirect registered (1 cycle).
module rob_dual_commit #(
    parameter int DEPTH_LOG = 4,
    parameter int REG_W     = 5,
    parameter int PRED_W    = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,

    input  logic                 alloc_valid,
    output logic                 alloc_ready,
    output logic [DEPTH_LOG-1:0] alloc_id,
    input  logic                 alloc_done,
    input  logic [31:0]          alloc_value,
    input  logic [1:0]           alloc_kind,
    input  logic [REG_W-1:0]     alloc_dest,
    input  logic [31:0]          alloc_next_pc,
    input  logic [31:0]          alloc_alt_pc,
    input  logic                 alloc_pred,

    input  logic                 wb0_valid,
    input  logic [DEPTH_LOG-1:0] wb0_id,
    input  logic [31:0]          wb0_data,
    input  logic                 wb0_target,
    input  logic                 wb1_valid,
    input  logic [DEPTH_LOG-1:0] wb1_id,
    input  logic [31:0]          wb1_data,
    input  logic                 wb1_target,

    input  logic [DEPTH_LOG-1:0] q0_id,
    output logic                 q0_ready,
    output logic [31:0]          q0_data,
    input  logic [DEPTH_LOG-1:0] q1_id,
    output logic                 q1_ready,
    output logic [31:0]          q1_data,

    output logic                 cmt0_valid,
    output logic [DEPTH_LOG-1:0] cmt0_id,
    output logic [REG_W-1:0]     cmt0_dest,
    output logic [31:0]          cmt0_data,
    output logic                 cmt1_valid,
    output logic [DEPTH_LOG-1:0] cmt1_id,
    output logic [REG_W-1:0]     cmt1_dest,
    output logic [31:0]          cmt1_data,

    output logic                 br_valid,
    output logic [PRED_W-1:0]    br_index,
    output logic                 br_taken,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic [DEPTH_LOG:0]   count,
    output logic                 empty,
    output logic [DEPTH_LOG-1:0] head_id
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] COUNT_FULL = (DEPTH_LOG+1)'(DEPTH);

    typedef struct packed {
        logic [31:0]      value;
        logic [1:0]       kind;
        logic [REG_W-1:0] dest;
        logic [31:0]      next_pc;
        logic [31:0]      alt_pc;
        logic             pred;
    } entry_t;

    entry_t               ent [DEPTH];
    logic [DEPTH-1:0]     present;
    logic [DEPTH-1:0]     done;
    logic [DEPTH-1:0]     present_nxt;
    logic [DEPTH-1:0]     done_nxt;
    logic [DEPTH_LOG-1:0] head;
    logic [DEPTH_LOG-1:0] tail;
    logic [DEPTH_LOG-1:0] head_next;

    logic       alloc_fire;
    logic       wb0_hit;
    logic       wb1_hit;
    logic       c0;
    logic       c1;
    logic       br0;
    logic       br1;
    logic       mispredict;
    logic [1:0] n_commit;
    entry_t     br_ent;

    assign head_next   = head + 1'b1;
    assign alloc_ready = (count != COUNT_FULL);
    assign empty       = (count == '0);
    assign head_id     = head;
    assign alloc_id    = tail;

    assign alloc_fire = rdy_in && alloc_valid && alloc_ready;
    assign wb0_hit    = rdy_in && wb0_valid && present[wb0_id];
    assign wb1_hit    = rdy_in && wb1_valid && present[wb1_id];

    // A branch in slot 0 stops slot 1 from committing, so at most one branch retires per cycle.
    assign c0       = present[head] && done[head];
    assign c1       = c0 && !ent[head].kind[1] && present[head_next] && done[head_next];
    assign n_commit = {1'b0, c0} + {1'b0, c1};

    assign br0        = c0 && ent[head].kind[1];
    assign br1        = c1 && ent[head_next].kind[1];
    assign br_ent     = br0 ? ent[head] : ent[head_next];
    assign br_valid   = br0 || br1;
    assign br_index   = br_ent.next_pc[PRED_W:1];
    assign br_taken   = br_ent.value[0];
    assign mispredict = br_valid && (br_ent.value[0] != br_ent.pred);

    assign cmt0_valid = c0;
    assign cmt0_id    = head;
    assign cmt0_dest  = ent[head].kind[0] ? ent[head].dest : '0;
    assign cmt0_data  = ent[head].value;
    assign cmt1_valid = c1;
    assign cmt1_id    = head_next;
    assign cmt1_dest  = ent[head_next].kind[0] ? ent[head_next].dest : '0;
    assign cmt1_data  = ent[head_next].value;

    always_comb begin
        present_nxt = present;
        done_nxt    = done;
        if (wb0_hit) done_nxt[wb0_id] = 1'b1;
        if (wb1_hit) done_nxt[wb1_id] = 1'b1;
        if (c0) begin
            present_nxt[head] = 1'b0;
            done_nxt[head]    = 1'b0;
        end
        if (c1) begin
            present_nxt[head_next] = 1'b0;
            done_nxt[head_next]    = 1'b0;
        end
        if (alloc_fire) begin
            present_nxt[tail] = 1'b1;
            done_nxt[tail]    = alloc_done;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            present        <= '0;
            done           <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                present        <= '0;
                done           <= '0;
                head           <= '0;
                tail           <= '0;
                count          <= '0;
                redirect_valid <= 1'b0;
            end else if (mispredict) begin
                present        <= '0;
                done           <= '0;
                head           <= '0;
                tail           <= '0;
                count          <= '0;
                redirect_valid <= 1'b1;
                redirect_pc    <= br_ent.pred ? br_ent.next_pc : br_ent.alt_pc;
            end else begin
                present        <= present_nxt;
                done           <= done_nxt;
                head           <= head + DEPTH_LOG'(n_commit);
                tail           <= tail + DEPTH_LOG'(alloc_fire);
                count          <= count + (DEPTH_LOG+1)'(alloc_fire) - (DEPTH_LOG+1)'(n_commit);
                redirect_valid <= 1'b0;
            end
        end
    end

    // Payload needs no reset: it is only observed through present/done.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush_in && !mispredict) begin
            if (alloc_fire)
                ent[tail] <= '{value: alloc_value, kind: alloc_kind, dest: alloc_dest,
                               next_pc: alloc_next_pc, alt_pc: alloc_alt_pc, pred: alloc_pred};
            if (wb0_hit) begin
                if (wb0_target) ent[wb0_id].alt_pc <= wb0_data;
                else            ent[wb0_id].value  <= wb0_data;
            end
            if (wb1_hit) begin
                if (wb1_target) ent[wb1_id].alt_pc <= wb1_data;
                else            ent[wb1_id].value  <= wb1_data;
            end
        end
    end

    // Later assignments take priority: alloc > wb1 > wb0 > stored.
    always_comb begin
        q0_ready = done[q0_id];
        q0_data  = ent[q0_id].value;
        if (wb0_hit && !wb0_target && wb0_id == q0_id) begin
            q0_ready = 1'b1;
            q0_data  = wb0_data;
        end
        if (wb1_hit && !wb1_target && wb1_id == q0_id) begin
            q0_ready = 1'b1;
            q0_data  = wb1_data;
        end
        if (alloc_fire && alloc_done && tail == q0_id) begin
            q0_ready = 1'b1;
            q0_data  = alloc_value;
        end
    end

    always_comb begin
        q1_ready = done[q1_id];
        q1_data  = ent[q1_id].value;
        if (wb0_hit && !wb0_target && wb0_id == q1_id) begin
            q1_ready = 1'b1;
            q1_data  = wb0_data;
        end
        if (wb1_hit && !wb1_target && wb1_id == q1_id) begin
            q1_ready = 1'b1;
            q1_data  = wb1_data;
        end
        if (alloc_fire && alloc_done && tail == q1_id) begin
            q1_ready = 1'b1;
            q1_data  = alloc_value;
        end
    end

endmodule

// File: tb/tb_rob_dual_commit.sv
// Bench for rob_dual_commit: directed scenarios plus random traffic against a queue-based ROB model.
module tb_rob_dual_commit;
    localparam int DL = 4;
    localparam int N  = 16;
    localparam int RW = 5;
    localparam int PW = 8;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, flush_in;
    logic          alloc_valid, alloc_ready, alloc_done, alloc_pred;
    logic [DL-1:0] alloc_id;
    logic [31:0]   alloc_value, alloc_next_pc, alloc_alt_pc;
    logic [1:0]    alloc_kind;
    logic [RW-1:0] alloc_dest;
    logic          wb0_valid, wb0_target, wb1_valid, wb1_target;
    logic [DL-1:0] wb0_id, wb1_id;
    logic [31:0]   wb0_data, wb1_data;
    logic [DL-1:0] q0_id, q1_id;
    logic          q0_ready, q1_ready;
    logic [31:0]   q0_data, q1_data;
    logic          cmt0_valid, cmt1_valid;
    logic [DL-1:0] cmt0_id, cmt1_id;
    logic [RW-1:0] cmt0_dest, cmt1_dest;
    logic [31:0]   cmt0_data, cmt1_data;
    logic          br_valid, br_taken, redirect_valid, empty;
    logic [PW-1:0] br_index;
    logic [31:0]   redirect_pc;
    logic [DL:0]   count;
    logic [DL-1:0] head_id;

    rob_dual_commit #(.DEPTH_LOG(DL), .REG_W(RW), .PRED_W(PW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .alloc_done(alloc_done), .alloc_value(alloc_value), .alloc_kind(alloc_kind),
        .alloc_dest(alloc_dest), .alloc_next_pc(alloc_next_pc), .alloc_alt_pc(alloc_alt_pc),
        .alloc_pred(alloc_pred),
        .wb0_valid(wb0_valid), .wb0_id(wb0_id), .wb0_data(wb0_data), .wb0_target(wb0_target),
        .wb1_valid(wb1_valid), .wb1_id(wb1_id), .wb1_data(wb1_data), .wb1_target(wb1_target),
        .q0_id(q0_id), .q0_ready(q0_ready), .q0_data(q0_data),
        .q1_id(q1_id), .q1_ready(q1_ready), .q1_data(q1_data),
        .cmt0_valid(cmt0_valid), .cmt0_id(cmt0_id), .cmt0_dest(cmt0_dest), .cmt0_data(cmt0_data),
        .cmt1_valid(cmt1_valid), .cmt1_id(cmt1_id), .cmt1_dest(cmt1_dest), .cmt1_data(cmt1_data),
        .br_valid(br_valid), .br_index(br_index), .br_taken(br_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .count(count), .empty(empty), .head_id(head_id)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int            id;
        bit            done;
        bit [31:0]     value;
        bit [1:0]      kind;
        bit [RW-1:0]   dest;
        bit [31:0]     next_pc;
        bit [31:0]     alt_pc;
        bit            pred;
    } rob_e;

    // Model: program-order queue of live entries; tail is the next id to hand out.
    rob_e      rob[$];
    int        m_tail;
    bit        m_rv;
    bit [31:0] m_rpc;
    bit        m_c0, m_c1, m_mis, m_acc;
    rob_e      m_b;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int find(input int id);
        foreach (rob[i]) if (rob[i].id == id) return i;
        return -1;
    endfunction

    task automatic model_query(input int id, output bit r, output bit [31:0] d);
        int k;
        k = find(id);
        r = 1'b0;
        d = '0;
        if (k >= 0 && rob[k].done) begin r = 1'b1; d = rob[k].value; end
        if (rdy_in && wb0_valid && !wb0_target && int'(wb0_id) == id && k >= 0) begin r = 1'b1; d = wb0_data; end
        if (rdy_in && wb1_valid && !wb1_target && int'(wb1_id) == id && k >= 0) begin r = 1'b1; d = wb1_data; end
        if (m_acc && alloc_done && m_tail == id) begin r = 1'b1; d = alloc_value; end
    endtask

    task automatic settle();
        bit qr;
        bit [31:0] qd;
        #1;
        m_acc = rdy_in && alloc_valid && (rob.size() != N);
        m_c0  = (rob.size() >= 1) && rob[0].done;
        m_c1  = m_c0 && !rob[0].kind[1] && (rob.size() >= 2) && rob[1].done;
        m_mis = 1'b0;
        if (m_c0 && rob[0].kind[1]) begin m_b = rob[0]; m_mis = 1'b1; end
        else if (m_c1 && rob[1].kind[1]) begin m_b = rob[1]; m_mis = 1'b1; end
        check("br_valid", br_valid, m_mis);
        if (m_mis) begin
            check("br_index", br_index, m_b.next_pc[PW:1]);
            check("br_taken", br_taken, m_b.value[0]);
        end
        m_mis = m_mis && (m_b.value[0] != m_b.pred);
        check("count", count, rob.size());
        check("empty", empty, rob.size() == 0);
        check("alloc_ready", alloc_ready, rob.size() != N);
        check("alloc_id", alloc_id, m_tail);
        check("head_id", head_id, (m_tail - rob.size() + N) % N);
        check("cmt0_valid", cmt0_valid, m_c0);
        if (m_c0) begin
            check("cmt0_id", cmt0_id, rob[0].id);
            check("cmt0_dest", cmt0_dest, rob[0].kind[0] ? rob[0].dest : 0);
            check("cmt0_data", cmt0_data, rob[0].value);
        end
        check("cmt1_valid", cmt1_valid, m_c1);
        if (m_c1) begin
            check("cmt1_id", cmt1_id, rob[1].id);
            check("cmt1_dest", cmt1_dest, rob[1].kind[0] ? rob[1].dest : 0);
            check("cmt1_data", cmt1_data, rob[1].value);
        end
        check("redirect_valid", redirect_valid, m_rv);
        check("redirect_pc", redirect_pc, m_rpc);
        model_query(int'(q0_id), qr, qd);
        check("q0_ready", q0_ready, qr);
        if (qr) check("q0_data", q0_data, qd);
        model_query(int'(q1_id), qr, qd);
        check("q1_ready", q1_ready, qr);
        if (qr) check("q1_data", q1_data, qd);
    endtask

    task automatic apply_wb(input bit v, input int id, input bit [31:0] d, input bit tgt);
        int k;
        rob_e e;
        k = find(id);
        if (v && k >= 0) begin
            e = rob[k];
            e.done = 1'b1;
            if (tgt) e.alt_pc = d;
            else     e.value  = d;
            rob[k] = e;
        end
    endtask

    task automatic advance();
        rob_e e;
        if (rdy_in) begin
            if (flush_in) begin
                rob.delete(); m_tail = 0; m_rv = 1'b0;
            end else if (m_mis) begin
                m_rpc = m_b.pred ? m_b.next_pc : m_b.alt_pc;
                rob.delete(); m_tail = 0; m_rv = 1'b1;
            end else begin
                m_rv = 1'b0;
                apply_wb(wb0_valid, int'(wb0_id), wb0_data, wb0_target);
                apply_wb(wb1_valid, int'(wb1_id), wb1_data, wb1_target);
                if (m_c0) void'(rob.pop_front());
                if (m_c1) void'(rob.pop_front());
                if (m_acc) begin
                    e = '{id: m_tail, done: alloc_done, value: alloc_value, kind: alloc_kind,
                          dest: alloc_dest, next_pc: alloc_next_pc, alt_pc: alloc_alt_pc, pred: alloc_pred};
                    rob.push_back(e);
                    m_tail = (m_tail + 1) % N;
                end
            end
        end
        @(negedge clk_in);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic idle();
        rdy_in = 1'b1; flush_in = 1'b0;
        alloc_valid = 1'b0; alloc_done = 1'b0; alloc_value = '0; alloc_kind = '0;
        alloc_dest = '0; alloc_next_pc = '0; alloc_alt_pc = '0; alloc_pred = 1'b0;
        wb0_valid = 1'b0; wb0_id = '0; wb0_data = '0; wb0_target = 1'b0;
        wb1_valid = 1'b0; wb1_id = '0; wb1_data = '0; wb1_target = 1'b0;
        q0_id = '0; q1_id = '0;
    endtask

    task automatic do_alloc(input bit d, input bit [31:0] v, input bit [1:0] k, input bit [RW-1:0] dst,
                            input bit [31:0] npc, input bit [31:0] apc, input bit p);
        alloc_valid = 1'b1; alloc_done = d; alloc_value = v; alloc_kind = k;
        alloc_dest = dst; alloc_next_pc = npc; alloc_alt_pc = apc; alloc_pred = p;
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
    endtask

    function automatic logic [DL-1:0] pick_id();
        if (rob.size() > 0 && $urandom_range(0, 4) != 0)
            return DL'(rob[$urandom_range(0, rob.size() - 1)].id);
        return DL'($urandom);
    endfunction

    initial begin
        idle();
        rst_in = 1'b0;
        rob.delete(); m_tail = 0; m_rv = 1'b0; m_rpc = '0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;

        // Post-reset state
        settle();
        check("rst_empty", empty, 1);
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_cmt0_valid", cmt0_valid, 0);
        check("rst_cmt1_valid", cmt1_valid, 0);
        check("rst_br_valid", br_valid, 0);
        check("rst_count", count, 0);
        advance();

        // Fill to capacity; the 17th alloc is ignored and tail has wrapped.
        for (int i = 0; i < N; i++) do_alloc(1'b0, 32'(i), 2'b01, RW'(i), 32'h0, 32'h0, 1'b0);
        settle();
        check("fill_count", count, 16);
        check("fill_alloc_ready", alloc_ready, 0);
        check("fill_tail_wrap", alloc_id, 0);
        advance();
        do_alloc(1'b0, 32'hdead, 2'b01, 5'd1, 32'h0, 32'h0, 1'b0);
        settle();
        check("fill_17th_ignored", count, 16);
        advance();
        do_flush();

        // Dual commit of two register-writing entries
        do_alloc(1'b0, 32'h0, 2'b01, 5'd3, 32'h0, 32'h0, 1'b0);
        do_alloc(1'b0, 32'h0, 2'b01, 5'd4, 32'h0, 32'h0, 1'b0);
        wb0_valid = 1'b1; wb0_id = 4'd0; wb0_data = 32'hA;
        wb1_valid = 1'b1; wb1_id = 4'd1; wb1_data = 32'hB;
        step();
        idle();
        settle();
        check("dual_cmt0_dest", cmt0_dest, 3);
        check("dual_cmt0_data", cmt0_data, 32'hA);
        check("dual_cmt1_valid", cmt1_valid, 1);
        check("dual_cmt1_dest", cmt1_dest, 4);
        check("dual_cmt1_data", cmt1_data, 32'hB);
        advance();
        settle();
        check("dual_head", head_id, 2);
        check("dual_count", count, 0);
        advance();
        do_flush();

        // Correctly predicted branch blocks slot 1 for one cycle
        do_alloc(1'b0, 32'h0, 2'b10, 5'd0, 32'h1234, 32'h8000, 1'b1);
        do_alloc(1'b0, 32'h0, 2'b01, 5'd7, 32'h0, 32'h0, 1'b0);
        wb0_valid = 1'b1; wb0_id = 4'd0; wb0_data = 32'h1;
        wb1_valid = 1'b1; wb1_id = 4'd1; wb1_data = 32'h55;
        step();
        idle();
        settle();
        check("br_cmt0_valid", cmt0_valid, 1);
        check("br_cmt1_blocked", cmt1_valid, 0);
        check("br_valid_slot0", br_valid, 1);
        check("br_taken_slot0", br_taken, 1);
        check("br_index_slot0", br_index, 8'h1A);
        advance();
        settle();
        check("br_no_redirect", redirect_valid, 0);
        check("br_next_cmt_id", cmt0_id, 1);
        check("br_next_cmt_data", cmt0_data, 32'h55);
        advance();
        do_flush();

        // Mispredicted branch with three younger entries
        do_alloc(1'b0, 32'h0, 2'b10, 5'd0, 32'h2000, 32'h1000, 1'b0);
        for (int i = 0; i < 3; i++) do_alloc(1'b0, 32'h0, 2'b01, 5'd9, 32'h0, 32'h0, 1'b0);
        wb0_valid = 1'b1; wb0_id = 4'd0; wb0_data = 32'h1;
        step();
        idle();
        step();
        settle();
        check("mis_redirect_valid", redirect_valid, 1);
        check("mis_redirect_pc", redirect_pc, 32'h1000);
        check("mis_count", count, 0);
        check("mis_empty", empty, 1);
        advance();
        settle();
        check("mis_redirect_drop", redirect_valid, 0);
        advance();

        // Same-entry writeback forwarding, wb1 wins
        for (int i = 0; i < 6; i++) do_alloc(1'b0, 32'h0, 2'b01, 5'd2, 32'h0, 32'h0, 1'b0);
        wb0_valid = 1'b1; wb0_id = 4'd5; wb0_data = 32'h11;
        wb1_valid = 1'b1; wb1_id = 4'd5; wb1_data = 32'h22;
        q0_id = 4'd5;
        settle();
        check("fwd_q0_ready", q0_ready, 1);
        check("fwd_q0_data", q0_data, 32'h22);
        advance();
        idle();
        q0_id = 4'd5;
        settle();
        check("fwd_stored_ready", q0_ready, 1);
        check("fwd_stored_data", q0_data, 32'h22);
        advance();
        do_flush();

        // Asynchronous reset between edges
        for (int i = 0; i < 7; i++) do_alloc(1'b0, 32'h0, 2'b01, 5'd1, 32'h0, 32'h0, 1'b0);
        settle();
        check("arst_pre_count", count, 7);
        #1;
        rst_in = 1'b0;
        rob.delete(); m_tail = 0; m_rv = 1'b0; m_rpc = '0;
        #1;
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        #1;
        rst_in = 1'b1;
        @(negedge clk_in);
        step();

        // Random traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rdy_in        = ($urandom_range(0, 9) != 0);
            flush_in      = ($urandom_range(0, 59) == 0);
            alloc_valid   = ($urandom_range(0, 9) < 6);
            alloc_done    = ($urandom_range(0, 3) == 0);
            alloc_value   = $urandom;
            alloc_kind[1] = ($urandom_range(0, 9) < 2);
            alloc_kind[0] = 1'($urandom_range(0, 1));
            alloc_dest    = RW'($urandom);
            alloc_next_pc = $urandom;
            alloc_alt_pc  = $urandom;
            alloc_pred    = 1'($urandom_range(0, 1));
            wb0_valid     = ($urandom_range(0, 1) == 0);
            wb0_id        = pick_id();
            wb0_data      = $urandom;
            wb0_target    = ($urandom_range(0, 3) == 0);
            wb1_valid     = ($urandom_range(0, 1) == 0);
            wb1_id        = ($urandom_range(0, 3) == 0) ? wb0_id : pick_id();
            wb1_data      = $urandom;
            wb1_target    = ($urandom_range(0, 3) == 0);
            q0_id         = pick_id();
            q1_id         = ($urandom_range(0, 3) == 0) ? alloc_id : pick_id();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
